adc_tap_align_ctrl: RTL and testbench
=====================================

# adc_tap_align_ctrl

Per-channel tap controller for the ADC input-alignment datapath. Owns the 6-bit shift-register tap code (bit 5 = delayed-path select, bits 4:0 = delay depth) of every ADC channel converter. Arbitrates between host writes and an automatic calibration sweep that finds, per channel, the first tap at which a calibration pulse lands on the reference strobe cycle.

## Interface
Parameters:
- NCH, 9: number of ADC channels.
- DATA_W, 13: signed converted sample width.
- SETTLE, 8: wait cycles after a tap change before sampling; must be at least 3.
- THRESH, 13'sd1024: signed detection threshold.
- TIMEOUT, 16'hFFFF: maximum cycles to wait for a strobe.

Ports:
- clk, in, 1: sample clock.
- rst_n, in, 1: asynchronous active-low reset.
- host_wr, in, 1: host write request; held high until host_ack.
- host_ch, in, 4: target channel.
- host_tap, in, 6: tap code to write.
- host_ack, out, 1: one-cycle accept pulse.
- cal_start, in, 1: pulse that requests a calibration sweep.
- cal_strobe, in, 1: reference-cycle marker.
- adc_din, in, NCH*DATA_W: converted channel samples, channel 0 in the LSBs.
- sr_tap_bus, out, NCH*6: registered tap codes, channel 0 in the LSBs.
- cal_busy, out, 1: sweep in progress.
- cal_done, out, 1: one-cycle pulse at sweep end.
- cal_fail, out, NCH: per-channel failure flags from the last sweep.

## Operation
- Reset values: all taps 6'd0, host_ack 0, cal_busy 0, cal_done 0, cal_fail 0, FSM in IDLE. A reset mid-sweep discards all sweep progress.
- Host write:
  - Accepted only in IDLE with no pending calibration.
  - host_ack pulses the cycle after acceptance, and the tap register updates in that same cycle.
  - If host_ch >= NCH, the write is acknowledged and ignored.
  - While cal_busy is high, host_ack is withheld and the request stalls.
- cal_start is latched as pending. A cal_start that arrives while busy is dropped.
- If host_wr and cal_start occur together in IDLE, the host write goes first and the sweep starts on the next cycle.
- Candidate order per channel: 6'b000000 (direct path), then 6'b100000 up to 6'b111111. This gives 33 candidates.
- FSM states and transitions:
  - IDLE -> APPLY: on pending calibration. Clears cal_fail, sets ch=0 and cand=0.
  - APPLY: writes the candidate tap to channel ch. -> SETTLE.
  - SETTLE: counts SETTLE cycles. -> ARM.
  - ARM: waits for cal_strobe while counting toward TIMEOUT.
    - On strobe: -> SAMPLE.
    - On timeout: sets cal_fail[ch], restores the pre-sweep tap, -> NEXT_CH.
  - SAMPLE: compares adc_din[ch] (signed) against THRESH.
    - If sample >= THRESH: locks the tap, -> NEXT_CH.
    - Otherwise: -> NEXT_TAP.
  - NEXT_TAP: advances cand -> APPLY. After cand 32, sets cal_fail[ch], restores the pre-sweep tap, -> NEXT_CH.
  - NEXT_CH: ch+1 -> APPLY. After ch = NCH-1, -> DONE.
  - DONE: pulses cal_done, clears cal_busy. -> IDLE.
- Arithmetic and widths:
  - ch counter is $clog2(NCH) bits.
  - cand counter is 6 bits.
  - Timeout counter is 16 bits and saturates (no wrap).
  - The comparison is signed, DATA_W bits wide.

## Timing
- sr_tap_bus is registered and changes exactly 1 cycle after APPLY.
- The datapath needs 3 further cycles (two tap sync registers plus the output register) before the new tap is visible; SETTLE covers this.
- adc_din is sampled in the cycle in which cal_strobe is high.
- Per-candidate sweep cost is at least 1 + SETTLE + strobe wait + 1 cycles.
- cal_busy rises the cycle after IDLE exits and falls in the same cycle as the cal_done pulse.

## Configuration
- Macro ADC_TAP_AUTOCAL_EN.
- When defined: calibration FSM, cal_* logic and timeout counter are compiled in.
- When undefined: host-write path only. cal_start and cal_strobe are ignored, cal_busy/cal_done/cal_fail are tied 0, and host writes are never stalled.

## Structure
- Shared package adc_tap_pkg holds:
  - TAP_DIRECT = 6'd0, TAP_DLY_BASE = 6'b100000, TAP_NCAND = 33.
  - FSM state encodings.
  - Default THRESH and TIMEOUT constants.
- One sub-module, adc_tap_regfile: NCH x 6-bit tap storage with a write port (channel, data, enable), save/restore of pre-sweep values, and the flattened sr_tap_bus output.

## Test plan
- Reset, then host write ch=2, tap=6'h25 -> host_ack pulses 1 cycle later; sr_tap_bus[17:12]=6'h25; all other channels stay 0.
- Host write ch=12 (>= NCH) -> host_ack pulses; sr_tap_bus unchanged.
- Sweep where the model pulse crosses THRESH at tap 6'h27 for every channel -> all taps = 6'h27, cal_fail=0, one cal_done pulse.
- Sweep where channel 4 never exceeds THRESH and was preset to 6'h22 -> cal_fail[4]=1 after 33 candidates; tap 4 restored to 6'h22.
- Strobe withheld during channel 0 with TIMEOUT=100 -> cal_fail[0]=1 after 100 cycles, sweep continues with channel 1; a host_wr issued meanwhile is acknowledged only after cal_done.
- rst_n asserted mid-sweep -> all taps 0, cal_busy 0 immediately; a following cal_start runs a full sweep normally.

Source files
------------

// File: rtl/adc_tap_pkg.sv
// Shared constants, FSM encoding and candidate-tap helper for the ADC tap alignment controller.
// The calibration sweep is compiled in only when ADC_TAP_AUTOCAL_EN is defined.
package adc_tap_pkg;

    localparam logic [5:0] TAP_DIRECT   = 6'd0;
    localparam logic [5:0] TAP_DLY_BASE = 6'b100000;
    localparam int         TAP_NCAND    = 33;

    localparam logic signed [12:0] THRESH_DEF  = 13'sd1024;
    localparam logic [15:0]        TIMEOUT_DEF = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_ARM,
        ST_SAMPLE,
        ST_NEXT_TAP,
        ST_NEXT_CH,
        ST_DONE
    } cal_state_t;

    // Candidate 0 is the direct path; candidates 1..32 walk the delayed path 0x20..0x3F.
    function automatic logic [5:0] cand_tap(input logic [5:0] cand);
        logic [4:0] depth;
        depth = cand[4:0] - 5'd1;
        return (cand == 6'd0) ? TAP_DIRECT : (TAP_DLY_BASE | {1'b0, depth});
    endfunction

endpackage

// File: rtl/adc_tap_regfile.sv
// Per-channel 6-bit tap registers with one write port, a shadow copy taken at sweep
// start, per-channel restore from that shadow, and the flattened tap bus output.
module adc_tap_regfile
    import adc_tap_pkg::*;
#(
    parameter int NCH   = 9,
    parameter int SEL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [SEL_W-1:0]   wr_ch,
    input  logic [5:0]         wr_data,
    input  logic               save,
    input  logic               restore,
    output logic [NCH*6-1:0]   tap_bus
);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [5:0] tap_reg;
            logic [5:0] shadow_reg;
            logic       sel;

            // Out-of-range channel numbers match no slot, so such writes fall away here.
            assign sel = (wr_ch == SEL_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tap_reg    <= TAP_DIRECT;
                    shadow_reg <= TAP_DIRECT;
                end else begin
                    if (save) begin
                        shadow_reg <= tap_reg;
                    end
                    if (sel && wr_en) begin
                        tap_reg <= wr_data;
                    end else if (sel && restore) begin
                        tap_reg <= shadow_reg;
                    end
                end
            end

            assign tap_bus[gi*6 +: 6] = tap_reg;
        end
    endgenerate

endmodule

// File: rtl/adc_tap_align_ctrl.sv
// ADC tap alignment controller: host tap writes plus an optional per-channel calibration
// sweep, compiled in when ADC_TAP_AUTOCAL_EN is defined.
module adc_tap_align_ctrl
    import adc_tap_pkg::*;
#(
    parameter int                       NCH     = 9,
    parameter int                       DATA_W  = 13,
    parameter int                       SETTLE  = 8,
    parameter logic signed [DATA_W-1:0] THRESH  = THRESH_DEF,
    parameter logic [15:0]              TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_wr,
    input  logic [3:0]            host_ch,
    input  logic [5:0]            host_tap,
    output logic                  host_ack,
    input  logic                  cal_start,
    input  logic                  cal_strobe,
    input  logic [NCH*DATA_W-1:0] adc_din,
    output logic [NCH*6-1:0]      sr_tap_bus,
    output logic                  cal_busy,
    output logic                  cal_done,
    output logic [NCH-1:0]        cal_fail
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SEL_W = (CH_W > 4) ? CH_W : 4;

    logic             ack_reg;
    logic             host_acc;
    logic             rf_wr_en;
    logic [SEL_W-1:0] rf_ch;
    logic [5:0]       rf_data;
    logic             rf_save;
    logic             rf_restore;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_reg <= 1'b0;
        else        ack_reg <= host_acc;
    end

    assign host_ack = ack_reg;

`ifdef ADC_TAP_AUTOCAL_EN
    cal_state_t               state_reg, state_next;
    logic                     pending_reg, busy_reg, done_reg;
    logic [NCH-1:0]           fail_reg;
    logic [CH_W-1:0]          ch_reg;
    logic [5:0]               cand_reg;
    logic [15:0]              cnt_reg;
    logic signed [DATA_W-1:0] sample_reg;
    logic signed [DATA_W-1:0] samples [NCH];
    logic                     hit;
    logic                     timeout_hit;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_smp
            assign samples[gi] = adc_din[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign hit         = (sample_reg >= THRESH);
    assign timeout_hit = (({1'b0, cnt_reg} + 17'd1) >= {1'b0, TIMEOUT});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        host_acc   = 1'b0;
        rf_wr_en   = 1'b0;
        rf_ch      = SEL_W'(ch_reg);
        rf_data    = cand_tap(cand_reg);
        rf_save    = 1'b0;
        rf_restore = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pending_reg) begin
                    rf_save    = 1'b1;
                    state_next = ST_APPLY;
                end else if (host_wr && !ack_reg) begin
                    host_acc = 1'b1;
                    rf_wr_en = 1'b1;
                    rf_ch    = SEL_W'(host_ch);
                    rf_data  = host_tap;
                end
            end
            ST_APPLY: begin
                rf_wr_en   = 1'b1;
                state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_reg == 16'(SETTLE - 1)) state_next = ST_ARM;
            end
            ST_ARM: begin
                if (cal_strobe) begin
                    state_next = ST_SAMPLE;
                end else if (timeout_hit) begin
                    rf_restore = 1'b1;
                    state_next = ST_NEXT_CH;
                end
            end
            ST_SAMPLE: begin
                state_next = hit ? ST_NEXT_CH : ST_NEXT_TAP;
            end
            ST_NEXT_TAP: begin
                if (cand_reg == 6'(TAP_NCAND - 1)) begin
                    rf_restore = 1'b1;
                    state_next = ST_NEXT_CH;
                end else begin
                    state_next = ST_APPLY;
                end
            end
            ST_NEXT_CH: begin
                state_next = (ch_reg == CH_W'(NCH - 1)) ? ST_DONE : ST_APPLY;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            fail_reg    <= '0;
            ch_reg      <= '0;
            cand_reg    <= 6'd0;
            cnt_reg     <= 16'd0;
            sample_reg  <= '0;
        end else begin
            done_reg <= (state_reg == ST_DONE);
            // A start request is only remembered while idle; during a sweep it is dropped.
            if (state_reg == ST_IDLE && pending_reg) begin
                pending_reg <= 1'b0;
                busy_reg    <= 1'b1;
                fail_reg    <= '0;
                ch_reg      <= '0;
                cand_reg    <= 6'd0;
            end else if (state_reg == ST_IDLE && cal_start) begin
                pending_reg <= 1'b1;
            end
            case (state_reg)
                ST_APPLY:  cnt_reg <= 16'd0;
                ST_SETTLE: cnt_reg <= (state_next == ST_ARM) ? 16'd0 : cnt_reg + 16'd1;
                ST_ARM:    cnt_reg <= (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
                default:   cnt_reg <= cnt_reg;
            endcase
            if (state_reg == ST_ARM && cal_strobe) begin
                sample_reg <= samples[ch_reg];
            end
            if (rf_restore) begin
                fail_reg[ch_reg] <= 1'b1;
            end
            if (state_reg == ST_NEXT_TAP && state_next == ST_APPLY) begin
                cand_reg <= cand_reg + 6'd1;
            end
            if (state_reg == ST_NEXT_CH && state_next == ST_APPLY) begin
                ch_reg   <= ch_reg + CH_W'(1);
                cand_reg <= 6'd0;
            end
            if (state_reg == ST_DONE) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign cal_busy = busy_reg;
    assign cal_done = done_reg;
    assign cal_fail = fail_reg;
`else
    logic unused_ok;

    always_comb begin
        host_acc   = host_wr && !ack_reg;
        rf_wr_en   = host_acc;
        rf_ch      = SEL_W'(host_ch);
        rf_data    = host_tap;
        rf_save    = 1'b0;
        rf_restore = 1'b0;
    end

    assign cal_busy  = 1'b0;
    assign cal_done  = 1'b0;
    assign cal_fail  = '0;
    assign unused_ok = ^{cal_start, cal_strobe, adc_din, THRESH, TIMEOUT, 16'(SETTLE)};
`endif

    adc_tap_regfile #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rf_wr_en),
        .wr_ch   (rf_ch),
        .wr_data (rf_data),
        .save    (rf_save),
        .restore (rf_restore),
        .tap_bus (sr_tap_bus)
    );

endmodule

// File: tb/tb_adc_tap_align_ctrl.sv
// Directed bench for adc_tap_align_ctrl; sweep scenarios run when ADC_TAP_AUTOCAL_EN is defined.
module tb_adc_tap_align_ctrl;

    localparam int NCH = 9;
    localparam int DW  = 13;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                host_wr = 1'b0;
    logic [3:0]          host_ch = 4'd0;
    logic [5:0]          host_tap = 6'd0;
    logic                host_ack;
    logic                cal_start = 1'b0;
    logic                cal_strobe = 1'b0;
    logic [NCH*DW-1:0]   adc_din;
    logic [NCH*6-1:0]    sr_tap_bus;
    logic                cal_busy;
    logic                cal_done;
    logic [NCH-1:0]      cal_fail;

    int                  checks = 0;
    int                  errors = 0;
    int                  done_cnt = 0;
    int                  sdiv = 0;
    logic                strobe_en = 1'b0;
    logic [6:0]          target [NCH];
    logic signed [DW-1:0] hit_val [NCH];
    logic [NCH*6-1:0]    exp_bus;

    adc_tap_align_ctrl #(
        .NCH     (NCH),
        .DATA_W  (DW),
        .SETTLE  (8),
        .THRESH  (13'sd1024),
        .TIMEOUT (16'd100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_wr    (host_wr),
        .host_ch    (host_ch),
        .host_tap   (host_tap),
        .host_ack   (host_ack),
        .cal_start  (cal_start),
        .cal_strobe (cal_strobe),
        .adc_din    (adc_din),
        .sr_tap_bus (sr_tap_bus),
        .cal_busy   (cal_busy),
        .cal_done   (cal_done),
        .cal_fail   (cal_fail)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cal_done) done_cnt++;
    end

    // Reference strobe every fourth cycle while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            sdiv = sdiv + 1;
            cal_strobe = strobe_en && ((sdiv % 4) == 0);
        end
    end

    // Pulse model: a channel sees hit_val once its delayed-path tap reaches target.
    always_comb begin
        logic [5:0] t;
        adc_din = '0;
        for (int c = 0; c < NCH; c++) begin
            t = sr_tap_bus[c*6 +: 6];
            adc_din[c*DW +: DW] = (t[5] && ({1'b0, t} >= target[c])) ? hit_val[c] : -13'sd200;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_exp_all(input logic [5:0] v);
        for (int c = 0; c < NCH; c++) exp_bus[c*6 +: 6] = v;
    endtask

    task automatic wait_done(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            step();
            if (cal_done) found = 1'b1;
        end
        chk(tag, found, 1'b1);
    endtask

    task automatic pulse_start();
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
    endtask

    initial begin
        int ack_at;
        int done_at;
        int d0;
        for (int c = 0; c < NCH; c++) begin
            target[c]  = 7'h27;
            hit_val[c] = 13'sd1500;
        end

        // Reset state
        step();
        step();
        chk("rst_bus", sr_tap_bus, '0);
        chk("rst_ack", host_ack, 1'b0);
        chk("rst_busy", cal_busy, 1'b0);
        chk("rst_done", cal_done, 1'b0);
        chk("rst_fail", cal_fail, '0);
        rst_n = 1'b1;
        step();

        // Host write ch2 = 0x25
        host_ch = 4'd2; host_tap = 6'h25; host_wr = 1'b1;
        step();
        chk("wr2_ack", host_ack, 1'b1);
        exp_bus = '0;
        exp_bus[17:12] = 6'h25;
        chk("wr2_bus", sr_tap_bus, exp_bus);
        host_wr = 1'b0;
        step();
        chk("wr2_ack_low", host_ack, 1'b0);

        // Host write to out-of-range channel 12
        host_ch = 4'd12; host_tap = 6'h3F; host_wr = 1'b1;
        step();
        chk("wr12_ack", host_ack, 1'b1);
        chk("wr12_bus", sr_tap_bus, exp_bus);
        host_wr = 1'b0;
        step();

`ifdef ADC_TAP_AUTOCAL_EN
        // Sweep 1: every channel locks at 0x27; ch1 hits exactly THRESH
        hit_val[1] = 13'sd1024;
        strobe_en = 1'b1;
        d0 = done_cnt;
        pulse_start();
        chk("s1_busy_e1", cal_busy, 1'b0);
        step();
        chk("s1_busy_e2", cal_busy, 1'b1);
        wait_done("s1_done_seen");
        chk("s1_busy_at_done", cal_busy, 1'b0);
        set_exp_all(6'h27);
        chk("s1_bus", sr_tap_bus, exp_bus);
        chk("s1_fail", cal_fail, '0);
        step();
        step();
        chk("s1_done_pulses", done_cnt - d0, 1);

        // Sweep 2: ch4 preset to 0x22, peaks at THRESH-1 and must fail and restore
        host_ch = 4'd4; host_tap = 6'h22; host_wr = 1'b1;
        step();
        chk("s2_pre_ack", host_ack, 1'b1);
        host_wr = 1'b0;
        step();
        hit_val[4] = 13'sd1023;
        pulse_start();
        wait_done("s2_done_seen");
        chk("s2_fail", cal_fail, 9'h010);
        set_exp_all(6'h27);
        exp_bus[29:24] = 6'h22;
        chk("s2_bus", sr_tap_bus, exp_bus);

        // Sweep 3: no strobe during ch0 -> timeout after 100 ARM cycles
        hit_val[4] = 13'sd1500;
        strobe_en = 1'b0;
        step();
        step();
        pulse_start();
        repeat (109) step();
        chk("s3_fail0_before", cal_fail[0], 1'b0);
        step();
        chk("s3_fail0_after", cal_fail[0], 1'b1);
        strobe_en = 1'b1;
        host_ch = 4'd2; host_tap = 6'h11; host_wr = 1'b1;
        ack_at = -1;
        done_at = -1;
        for (int i = 0; i < 6000 && ack_at < 0; i++) begin
            step();
            if (cal_done) done_at = i;
            if (host_ack) ack_at = i;
        end
        host_wr = 1'b0;
        chk("s3_ack_seen", (ack_at >= 0), 1'b1);
        chk("s3_ack_after_done", ack_at - done_at, 1);
        chk("s3_fail", cal_fail, 9'h001);
        set_exp_all(6'h27);
        exp_bus[17:12] = 6'h11;
        chk("s3_bus", sr_tap_bus, exp_bus);
        step();

        // Sweep 4: reset mid-sweep, then a concurrent host write + start
        pulse_start();
        repeat (60) step();
        chk("s4_busy_mid", cal_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s4_rst_bus", sr_tap_bus, '0);
        chk("s4_rst_busy", cal_busy, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        d0 = done_cnt;
        host_ch = 4'd3; host_tap = 6'h15; host_wr = 1'b1; cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        chk("s4_ack", host_ack, 1'b1);
        chk("s4_busy_e1", cal_busy, 1'b0);
        exp_bus = '0;
        exp_bus[23:18] = 6'h15;
        chk("s4_wr_bus", sr_tap_bus, exp_bus);
        host_wr = 1'b0;
        step();
        chk("s4_busy_e2", cal_busy, 1'b1);
        wait_done("s4_done_seen");
        set_exp_all(6'h27);
        chk("s4_bus", sr_tap_bus, exp_bus);
        chk("s4_fail", cal_fail, '0);
        step();
        step();
        chk("s4_done_pulses", done_cnt - d0, 1);
`else
        // Calibration compiled out: start/strobe ignored, host never stalled
        strobe_en = 1'b1;
        host_ch = 4'd3; host_tap = 6'h15; host_wr = 1'b1; cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        chk("nc_ack", host_ack, 1'b1);
        exp_bus[23:18] = 6'h15;
        chk("nc_bus", sr_tap_bus, exp_bus);
        host_wr = 1'b0;
        repeat (200) step();
        chk("nc_busy", cal_busy, 1'b0);
        chk("nc_done_cnt", done_cnt, 0);
        chk("nc_fail", cal_fail, '0);
        chk("nc_bus_hold", sr_tap_bus, exp_bus);
        host_ch = 4'd8; host_tap = 6'h3F; host_wr = 1'b1;
        step();
        chk("nc_ack8", host_ack, 1'b1);
        exp_bus[53:48] = 6'h3F;
        chk("nc_bus8", sr_tap_bus, exp_bus);
        host_wr = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
